// File: rtl/traf_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : traf_sched_if
// Description : Sensor inputs and lamp outputs of the traffic scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface traf_sched_if;
    logic       side_req;
    logic       ped_req;
    logic [1:0] highway;
    logic [1:0] side;
    logic       walk;
    logic       ped_ack;

    modport master (
        output side_req, ped_req,
        input  highway, side, walk, ped_ack
    );

    modport slave (
        input  side_req, ped_req,
        output highway, side, walk, ped_ack
    );
endinterface
`default_nettype wire

// File: rtl/traf_sched.sv
`default_nettype none
// ============================================================================
// Module      : traf_sched
// Description : Highway / side-road / pedestrian signal scheduler, Moore FSM
//               with a saturating dwell counter. Define TRAF_SCHED_PED_EN to
//               build the pedestrian walk phase.
// Revision    : 1.0 - initial release
// ============================================================================
module traf_sched #(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 6
) (
    input  logic         clk,
    input  logic         rst,
    traf_sched_if.slave  bus
);

    localparam logic [2:0] S_HG  = 3'd0;
    localparam logic [2:0] S_HY  = 3'd1;
    localparam logic [2:0] S_AR1 = 3'd2;
    localparam logic [2:0] S_PW  = 3'd3;
    localparam logic [2:0] S_SG  = 3'd4;
    localparam logic [2:0] S_SY  = 3'd5;
    localparam logic [2:0] S_AR2 = 3'd6;

    localparam logic [15:0] c_green_min = 16'(GREEN_MIN);
    localparam logic [15:0] c_green_max = 16'(GREEN_MAX);
    localparam logic [15:0] c_yellow_t  = 16'(YELLOW_T);
    localparam logic [15:0] c_allred_t  = 16'(ALLRED_T);
    localparam logic [15:0] c_dwell_sat = 16'hFFFF;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [15:0] r_dwell;
    logic        w_ped_pend;
    logic [1:0]  w_highway;
    logic [1:0]  w_side;
    logic        w_walk;
    logic        w_ped_ack;

`ifdef TRAF_SCHED_PED_EN
    localparam logic [15:0] c_walk_t = 16'(WALK_T);
    logic r_ped_pend;
    logic w_enter_pw;

    assign w_enter_pw = (w_next == S_PW) && (r_state != S_PW);
    assign w_ped_pend = r_ped_pend;

    // A new request on the clearing edge takes priority so it is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ped_pend <= 1'b0;
        end else if (bus.ped_req) begin
            r_ped_pend <= 1'b1;
        end else if (w_enter_pw) begin
            r_ped_pend <= 1'b0;
        end
    end
`else
    localparam int c_unused_walk_t = WALK_T;
    logic w_unused_ped_req;

    assign w_unused_ped_req = bus.ped_req;
    assign w_ped_pend       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_HG;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dwell <= 16'd0;
        end else if (w_next != r_state) begin
            r_dwell <= 16'd1;
        end else if (r_dwell != c_dwell_sat) begin
            r_dwell <= r_dwell + 16'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HG: begin
                if ((r_dwell >= c_green_min) && (bus.side_req || w_ped_pend)) begin
                    w_next = S_HY;
                end
            end
            S_HY: begin
                if (r_dwell >= c_yellow_t) begin
                    w_next = S_AR1;
                end
            end
            S_AR1: begin
                if (r_dwell >= c_allred_t) begin
`ifdef TRAF_SCHED_PED_EN
                    w_next = w_ped_pend ? S_PW : S_SG;
`else
                    w_next = S_SG;
`endif
                end
            end
`ifdef TRAF_SCHED_PED_EN
            S_PW: begin
                if (r_dwell >= c_walk_t) begin
                    w_next = bus.side_req ? S_SG : S_AR2;
                end
            end
`else
            S_PW:    w_next = S_AR2;
`endif
            S_SG: begin
                if (((r_dwell >= c_green_min) && !bus.side_req) || (r_dwell >= c_green_max)) begin
                    w_next = S_SY;
                end
            end
            S_SY: begin
                if (r_dwell >= c_yellow_t) begin
                    w_next = S_AR2;
                end
            end
            S_AR2: begin
                if (r_dwell >= c_allred_t) begin
                    w_next = S_HG;
                end
            end
            default: w_next = S_AR2;
        endcase
    end

    always_comb begin
        w_highway = 2'b00;
        w_side    = 2'b00;
        w_walk    = 1'b0;
        w_ped_ack = 1'b0;
        case (r_state)
            S_HG: w_highway = 2'b10;
            S_HY: w_highway = 2'b01;
            S_SG: w_side    = 2'b10;
            S_SY: w_side    = 2'b01;
`ifdef TRAF_SCHED_PED_EN
            S_PW: begin
                w_walk    = 1'b1;
                w_ped_ack = (r_dwell == 16'd1);
            end
`endif
            default: begin
                w_highway = 2'b00;
                w_side    = 2'b00;
            end
        endcase
    end

    assign bus.highway = w_highway;
    assign bus.side    = w_side;
    assign bus.walk    = w_walk;
    assign bus.ped_ack = w_ped_ack;

endmodule
`default_nettype wire

// File: tb/tb_traf_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_traf_sched
// Description : Directed scoreboard bench for traf_sched lamp sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traf_sched;

    // {highway, side, walk, ped_ack}
    localparam logic [5:0] E_HG  = 6'b10_00_0_0;
    localparam logic [5:0] E_HY  = 6'b01_00_0_0;
    localparam logic [5:0] E_AR  = 6'b00_00_0_0;
    localparam logic [5:0] E_SG  = 6'b00_10_0_0;
    localparam logic [5:0] E_SY  = 6'b00_01_0_0;
    localparam logic [5:0] E_PW  = 6'b00_00_1_0;
    localparam logic [5:0] E_PWA = 6'b00_00_1_1;

    typedef struct {
        logic [5:0] exp;
        string      tag;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    exp_t  q[$];
    string cur_tag = "reset";
    int    n_vec = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    traf_sched_if bus ();

    traf_sched #(
        .GREEN_MIN (8),
        .GREEN_MAX (20),
        .YELLOW_T  (3),
        .ALLRED_T  (2),
        .WALK_T    (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Monitor: compare one queued expectation per cycle, mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t  e;
            logic [5:0] act;
            e   = q.pop_front();
            act = {bus.highway, bus.side, bus.walk, bus.ped_ack};
            n_vec++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: lamps got %b want %b (t=%0t)", e.tag, act, e.exp, $time);
            end
        end
    end

    task automatic cyc(input logic s, input logic p, input logic [5:0] e);
        bus.side_req = s;
        bus.ped_req  = p;
        q.push_back('{e, cur_tag});
        @(posedge clk);
        #1;
    endtask

    task automatic seg(input logic s, input logic p, input logic [5:0] e, input int n);
        for (int i = 0; i < n; i++) cyc(s, p, e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        seg(1'b0, 1'b0, E_HG, 2);
        rst = 1'b0;
    endtask

    initial begin
        bus.side_req = 1'b0;
        bus.ped_req  = 1'b0;
        @(posedge clk);
        #1;

        cur_tag = "reset";
        do_reset();

        cur_tag = "idle_hold";
        seg(1'b0, 1'b0, E_HG, 101);

        cur_tag = "side_max";
        do_reset();
        seg(1'b1, 1'b0, E_HG, 9);
        seg(1'b1, 1'b0, E_HY, 3);
        seg(1'b1, 1'b0, E_AR, 2);
        seg(1'b1, 1'b0, E_SG, 20);
        seg(1'b1, 1'b0, E_SY, 3);
        seg(1'b1, 1'b0, E_AR, 2);
        seg(1'b0, 1'b0, E_HG, 3);

        cur_tag = "side_pulse";
        do_reset();
        seg(1'b0, 1'b0, E_HG, 3);
        cyc(1'b1, 1'b0, E_HG);
        seg(1'b0, 1'b0, E_HG, 20);

        cur_tag = "side_drop";
        do_reset();
        seg(1'b1, 1'b0, E_HG, 9);
        seg(1'b1, 1'b0, E_HY, 3);
        seg(1'b1, 1'b0, E_AR, 2);
        seg(1'b1, 1'b0, E_SG, 4);
        seg(1'b0, 1'b0, E_SG, 4);
        seg(1'b0, 1'b0, E_SY, 3);
        seg(1'b0, 1'b0, E_AR, 2);
        seg(1'b0, 1'b0, E_HG, 3);

`ifdef TRAF_SCHED_PED_EN
        cur_tag = "ped_walk";
        do_reset();
        seg(1'b0, 1'b0, E_HG, 2);
        cyc(1'b0, 1'b1, E_HG);
        seg(1'b0, 1'b0, E_HG, 6);
        seg(1'b0, 1'b0, E_HY, 3);
        seg(1'b0, 1'b0, E_AR, 2);
        cyc(1'b0, 1'b0, E_PWA);
        seg(1'b0, 1'b0, E_PW, 5);
        seg(1'b0, 1'b0, E_AR, 2);
        seg(1'b0, 1'b0, E_HG, 3);

        cur_tag = "ped_in_walk";
        do_reset();
        seg(1'b0, 1'b0, E_HG, 2);
        cyc(1'b0, 1'b1, E_HG);
        seg(1'b0, 1'b0, E_HG, 6);
        seg(1'b0, 1'b0, E_HY, 3);
        seg(1'b0, 1'b0, E_AR, 2);
        cyc(1'b0, 1'b0, E_PWA);
        seg(1'b0, 1'b1, E_PW, 2);
        seg(1'b0, 1'b0, E_PW, 3);
        seg(1'b0, 1'b0, E_AR, 2);
        seg(1'b0, 1'b0, E_HG, 8);
        seg(1'b0, 1'b0, E_HY, 3);
        seg(1'b0, 1'b0, E_AR, 2);
        cyc(1'b0, 1'b0, E_PWA);
`else
        cur_tag = "ped_ignored";
        do_reset();
        seg(1'b0, 1'b1, E_HG, 30);
        seg(1'b0, 1'b0, E_HG, 3);
`endif

        cur_tag = "async_reset";
        do_reset();
        seg(1'b1, 1'b0, E_HG, 9);
        seg(1'b1, 1'b0, E_HY, 3);
        seg(1'b1, 1'b0, E_AR, 2);
        seg(1'b1, 1'b0, E_SG, 3);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.highway, bus.side, bus.walk, bus.ped_ack} !== E_HG) begin
            n_err++;
            $display("FAIL async_reset: lamps got %b want %b",
                     {bus.highway, bus.side, bus.walk, bus.ped_ack}, E_HG);
        end
        @(posedge clk);
        #1;
        do_reset();
        seg(1'b0, 1'b0, E_HG, 3);

        @(negedge clk);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: queue depth got %0d want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traf_sched.md
TRAF_SCHED -- requirements
Module: traf_sched

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  GREEN_MIN, 8: minimum green dwell in cycles, either road.
  GREEN_MAX, 20: maximum side-road green dwell in cycles.
  YELLOW_T, 3: yellow dwell in cycles.
  ALLRED_T, 2: all-red clearance dwell in cycles.
  WALK_T, 6: pedestrian walk dwell in cycles.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  single clock; all state changes on its rising edge.
  rst  in  1  reset; asynchronous, active-high.
  side_req  in  1  side-road vehicle sensor (level).
  ped_req  in  1  pedestrian button (pulse or level).
  highway  out  2  highway lamp: 10 green, 01 yellow, 00 red.
  side  out  2  side-road lamp, same encoding.
  walk  out  1  pedestrian walk lamp.
  ped_ack  out  1  one-cycle pulse when a pedestrian request is served.

Function
REQ-003 The FSM SHALL have seven states: HG (highway green), HY, AR1, PW (pedestrian walk), SG (side green), SY, AR2.
REQ-004 The lamp outputs SHALL be a pure Moore decode of the state register, with no combinational input-to-output path.
REQ-005 Decode: HG gives highway=10/side=00; HY gives 01/00; SG gives 00/10; SY gives 00/01; AR1, AR2 and PW give 00/00; walk=1 only in PW.
REQ-006 A dwell counter (16 bits, saturating) SHALL read 1 in the first cycle of each state and SHALL reload to 1 on every state change.
REQ-007 HG SHALL exit to HY at the end of the cycle where dwell>=GREEN_MIN and (side_req or ped_pend); otherwise HG holds indefinitely.
REQ-008 HY SHALL exit to AR1 after exactly YELLOW_T cycles; SY SHALL exit to AR2 after exactly YELLOW_T cycles.
REQ-009 AR1 SHALL last exactly ALLRED_T cycles, then go to PW if ped_pend=1, else to SG.
REQ-010 PW SHALL last exactly WALK_T cycles, then go to SG if side_req=1, else to AR2.
REQ-011 SG SHALL exit to SY when (dwell>=GREEN_MIN and side_req=0) or dwell==GREEN_MAX, whichever comes first.
REQ-012 AR2 SHALL last exactly ALLRED_T cycles, then go to HG.
REQ-013 ped_pend SHALL set on any cycle with ped_req=1.
REQ-014 ped_pend SHALL clear on the cycle PW is entered, and ped_ack SHALL pulse high for that single cycle.
REQ-015 If ped_req=1 on the same cycle ped_pend is cleared, set SHALL win, so the request is retained for the next cycle.
REQ-016 A ped_req during PW SHALL NOT extend PW; it is served on the next pass.
REQ-017 The FSM SHALL never drive green or yellow on both roads at once, and every change of right-of-way SHALL pass through AR1 or AR2 (PW counts as all-red for the side).
REQ-018 Unreachable state encodings SHALL recover to AR2 on the next clock.

Reset
REQ-019 While rst=1, state SHALL be HG, dwell=0, ped_pend=0, highway=10, side=00, walk=0 and ped_ack=0, immediately and independent of clk.
REQ-020 Reset asserted mid-cycle in any state SHALL abort that state with no yellow or all-red completion.
REQ-021 After rst deasserts, the first rising edge SHALL set dwell=1 in HG.

Configuration
REQ-022 Macro TRAF_SCHED_PED_EN defined: the pedestrian path (ped_pend, PW, walk, ped_ack) SHALL be implemented as above.
REQ-023 Macro TRAF_SCHED_PED_EN undefined: ped_req SHALL be ignored, walk and ped_ack SHALL be tied 0, ped_pend SHALL be constant 0, and PW SHALL be removed, so AR1 always goes to SG.

Verification
REQ-024 The bench SHALL cover these directed scenarios (default parameters):
  - side_req=0, ped_req=0 for 100 cycles after reset -> highway=10 throughout, side=00.
  - side_req=1 held from cycle 0 -> HG 8 cycles, HY 3, AR1 2, then SG for 20 cycles (GREEN_MAX), SY 3, AR2 2, then HG.
  - side_req pulsed for 1 cycle at dwell 3 of HG -> no transition (request not latched); HG holds.
  - side_req=1 then dropped at SG dwell 5 -> SY begins after SG dwell 8.
  - ped_req pulse at HG dwell 2, side_req=0 -> HY at dwell 8, AR1, PW for 6 cycles with walk=1, ped_ack=1 on PW entry only, then AR2 then HG.
  - rst pulse during SG dwell 4 -> highway=10 and side=00 with no clock edge; walk=0.
  - With TRAF_SCHED_PED_EN undefined, ped_req=1 only -> stays in HG, walk=0.
